// File: rtl/uart_loader.sv
// Boot loader: assembles little-endian words from a UART byte stream into imem, then dmem,
// then releases the CPU. Optional trailing checksum word enabled by LOADER_CHECKSUM_EN.
module uart_loader #(
    parameter int IMEM_ENTRIES = 4096,
    parameter int DMEM_ENTRIES = 4096,
    parameter int IMEM_AW      = $clog2(IMEM_ENTRIES),
    parameter int DMEM_AW      = $clog2(DMEM_ENTRIES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               rvalid_i,
    output logic               rready_o,
    input  logic [7:0]         rdata_i,
    output logic               imem_we_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic [31:0]        imem_wdata_o,
    output logic               dmem_we_o,
    output logic [DMEM_AW-1:0] dmem_addr_o,
    output logic [31:0]        dmem_wdata_o,
    output logic               cpu_rst_o,
    output logic               done_o,
    output logic               err_o
);

    // One spare bit so the index never wraps before reaching its terminal value.
    localparam int WW = ((IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW) + 1;
    localparam logic [WW-1:0] IMEM_LAST = WW'(IMEM_ENTRIES - 1);
    localparam logic [WW-1:0] DMEM_LAST = WW'(DMEM_ENTRIES - 1);

    typedef enum logic [1:0] {
        ST_IMEM = 2'd0,
        ST_DMEM = 2'd1,
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM = 2'd2,
`endif
        ST_DONE = 2'd3
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [1:0]    lane_r, lane_nxt_s;
    logic [23:0]   part_r, part_nxt_s;
    logic [WW-1:0] widx_r, widx_nxt_s;
    logic          xfer_s;
    logic          imem_we_s;
    logic          dmem_we_s;
    logic [31:0]   word_s;
`ifdef LOADER_CHECKSUM_EN
    logic          csum_done_s;
    logic [31:0]   sum_r;
`endif

    // Next-state, lane/index advance and write-strobe decode.
    always_comb begin
        state_nxt_s = state_r;
        lane_nxt_s  = lane_r;
        part_nxt_s  = part_r;
        widx_nxt_s  = widx_r;
        imem_we_s   = 1'b0;
        dmem_we_s   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_done_s = 1'b0;
`endif
        xfer_s      = rvalid_i & rready_o;
        word_s      = {rdata_i, part_r};
        if (xfer_s) begin
            lane_nxt_s = lane_r + 2'd1;
            // Shift right so the first byte ends up in the least significant lane.
            part_nxt_s = {rdata_i, part_r[23:8]};
            if (lane_r == 2'd3) begin
                case (state_r)
                    ST_IMEM: begin
                        imem_we_s = 1'b1;
                        if (widx_r == IMEM_LAST) begin
                            widx_nxt_s  = {WW{1'b0}};
                            state_nxt_s = ST_DMEM;
                        end else begin
                            widx_nxt_s  = widx_r + WW'(1);
                        end
                    end
                    ST_DMEM: begin
                        dmem_we_s = 1'b1;
                        if (widx_r == DMEM_LAST) begin
                            widx_nxt_s  = {WW{1'b0}};
`ifdef LOADER_CHECKSUM_EN
                            state_nxt_s = ST_CSUM;
`else
                            state_nxt_s = ST_DONE;
`endif
                        end else begin
                            widx_nxt_s  = widx_r + WW'(1);
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    ST_CSUM: begin
                        csum_done_s = 1'b1;
                        state_nxt_s = ST_DONE;
                    end
`endif
                    default: begin
                        state_nxt_s = state_r;
                    end
                endcase
            end else begin
                state_nxt_s = state_r;
            end
        end else begin
            lane_nxt_s = lane_r;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IMEM;
            lane_r       <= 2'd0;
            part_r       <= 24'd0;
            widx_r       <= {WW{1'b0}};
            imem_we_o    <= 1'b0;
            imem_addr_o  <= {IMEM_AW{1'b0}};
            imem_wdata_o <= 32'd0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= {DMEM_AW{1'b0}};
            dmem_wdata_o <= 32'd0;
            rready_o     <= 1'b1;
            cpu_rst_o    <= 1'b1;
            done_o       <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            lane_r    <= lane_nxt_s;
            part_r    <= part_nxt_s;
            widx_r    <= widx_nxt_s;
            imem_we_o <= imem_we_s;
            dmem_we_o <= dmem_we_s;
            if (imem_we_s) begin
                imem_addr_o  <= widx_r[IMEM_AW-1:0];
                imem_wdata_o <= word_s;
            end
            if (dmem_we_s) begin
                dmem_addr_o  <= widx_r[DMEM_AW-1:0];
                dmem_wdata_o <= word_s;
            end
            rready_o  <= (state_nxt_s != ST_DONE);
            cpu_rst_o <= (state_nxt_s != ST_DONE);
            done_o    <= (state_nxt_s == ST_DONE);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running sum of every written word and the sticky checksum verdict.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_r <= 32'd0;
            err_o <= 1'b0;
        end else begin
            if (imem_we_s || dmem_we_s) begin
                sum_r <= sum_r + word_s;
            end
            if (csum_done_s) begin
                err_o <= (word_s != sum_r);
            end
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_loader.sv
// Randomized scoreboard bench for uart_loader (IMEM_ENTRIES=4, DMEM_ENTRIES=2).
module tb_uart_loader;

    localparam int NI = 4;
    localparam int ND = 2;
`ifdef LOADER_CHECKSUM_EN
    localparam int  TOTAL = 4 * (NI + ND) + 4;
    localparam bit  CSUM  = 1'b1;
`else
    localparam int  TOTAL = 4 * (NI + ND);
    localparam bit  CSUM  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rvalid = 1'b0;
    logic [7:0]  rdata = 8'd0;
    logic        rready;
    logic        imem_we, dmem_we, cpu_rst, done, err;
    logic [1:0]  imem_addr;
    logic [0:0]  dmem_addr;
    logic [31:0] imem_wdata, dmem_wdata;

    uart_loader #(.IMEM_ENTRIES(NI), .DMEM_ENTRIES(ND)) dut (
        .clk_i(clk), .rst_i(rst), .rvalid_i(rvalid), .rready_o(rready), .rdata_i(rdata),
        .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
        .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
        .cpu_rst_o(cpu_rst), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          dm;
        int          addr;
        logic [31:0] data;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] w[7];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          prev_we  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe is matched against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we || dmem_we) begin
                if (prev_we) chk("no_back_to_back", 32'd1, 32'd0);
                if (imem_we && dmem_we) chk("single_strobe", 32'd1, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {31'd0, dmem_we}, {31'd0, imem_we});
                    chk("unexpected_strobe_any", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("strobe_target", {31'd0, dmem_we}, {31'd0, e.dm});
                    if (e.dm) begin
                        chk("dmem_addr", {31'd0, dmem_addr}, e.addr);
                        chk("dmem_wdata", dmem_wdata, e.data);
                    end else begin
                        chk("imem_addr", {30'd0, imem_addr}, e.addr);
                        chk("imem_wdata", imem_wdata, e.data);
                    end
                    chk("done_with_last_write", {31'd0, done}, {31'd0, e.last && !CSUM});
                    chk("cpu_rst_with_last_write", {31'd0, cpu_rst}, {31'd0, !(e.last && !CSUM)});
                end
            end
            chk("done_vs_cpu_rst", {31'd0, done}, {31'd0, ~cpu_rst});
        end
        prev_we <= imem_we | dmem_we;
    end

    task automatic idle(input int n);
        rvalid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rvalid = 1'b1;
        rdata  = b;
        while (!rready && n < 50) begin @(posedge clk); #1; n++; end
        if (!rready) begin
            chk("handshake_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rready", {31'd0, rready}, 32'd1);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_imem_addr", {30'd0, imem_addr}, 32'd0);
        chk("rst_dmem_addr", {31'd0, dmem_addr}, 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        exp_q.delete();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] sum6();
        logic [31:0] s = 32'd0;
        for (int k = 0; k < 6; k++) s += w[k];
        return s;
    endfunction

    task automatic randomize_words(input bit bad_sum);
        for (int k = 0; k < 6; k++) w[k] = $urandom;
        w[6] = sum6() + (bad_sum ? 32'd1 + 32'($urandom_range(1000, 0)) : 32'd0);
    endtask

    // Stream nbytes of the image; the model knows which word lands where.
    task automatic load(input int nbytes, input int stall_pct, input bit long_stall);
        for (int i = 0; i < nbytes; i++) begin
            logic [31:0] wd;
            wd = w[i / 4];
            if (stall_pct > 0 && $urandom_range(99, 0) < stall_pct) idle($urandom_range(3, 1));
            if (long_stall && i == 7) idle(100);
            send_byte(wd[8 * (i % 4) +: 8]);
            if (i % 4 == 3 && i / 4 < NI + ND) begin
                exp_t e;
                e.dm   = (i / 4 >= NI);
                e.addr = e.dm ? i / 4 - NI : i / 4;
                e.data = wd;
                e.last = (i / 4 == NI + ND - 1);
                exp_q.push_back(e);
            end
        end
        rvalid = 1'b0;
    endtask

    task automatic check_done();
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        chk("writes_drained", exp_q.size(), 32'd0);
        chk("final_done", {31'd0, done}, 32'd1);
        chk("final_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("final_rready", {31'd0, rready}, 32'd0);
        chk("final_err", {31'd0, err}, {31'd0, CSUM && (w[6] != sum6())});
    endtask

    initial begin
        do_reset();

        // Word assembly and back-to-back full load, then a held extra byte.
        randomize_words(1'b0);
        w[0] = 32'h12345678;
        w[6] = sum6();
        load(TOTAL, 0, 1'b0);
        check_done();
        rvalid = 1'b1;
        rdata  = 8'hAA;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("extra_byte_rready", {31'd0, rready}, 32'd0);
        end
        chk("extra_byte_done", {31'd0, done}, 32'd1);
        rvalid = 1'b0;

        // Long stall mid-word plus random idle gaps.
        do_reset();
        randomize_words(1'b0);
        load(TOTAL, 30, 1'b1);
        check_done();

        // Reset after 10 bytes, then a fresh load.
        do_reset();
        randomize_words(1'b0);
        load(10, 0, 1'b0);
        repeat (2) @(negedge clk);
        chk("partial_writes", exp_q.size(), 32'd0);
        chk("partial_not_done", {31'd0, done}, 32'd0);
        do_reset();
        randomize_words(1'b0);
        load(TOTAL, 10, 1'b0);
        check_done();

`ifdef LOADER_CHECKSUM_EN
        for (int k = 0; k < 6; k++) w[k] = 32'(k + 1);
        w[6] = 32'h15;
        do_reset();
        load(TOTAL, 0, 1'b0);
        check_done();
        w[6] = 32'h16;
        do_reset();
        load(TOTAL, 0, 1'b0);
        check_done();
`endif

        for (int r = 0; r < 4; r++) begin
            do_reset();
            randomize_words(CSUM && r[0]);
            load(TOTAL, 25, 1'b0);
            check_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/uart_loader.md
# uart_loader

Boot-time program loader inside `main`, directly downstream of the UART receiver. It consumes the raw byte stream the host or testbench pushes over `rxd_i`, assembles little-endian 32-bit words, and writes them first into instruction memory, then into data memory. When both images are complete it releases the CPU from reset and stops accepting bytes.

## Interface
- `IMEM_ENTRIES`, default 4096: number of 32-bit words in the instruction image; must be ≥1.
- `DMEM_ENTRIES`, default 4096: number of 32-bit words in the data image; must be ≥1.
- `IMEM_AW`, default `$clog2(IMEM_ENTRIES)`: width of the imem word address.
- `DMEM_AW`, default `$clog2(DMEM_ENTRIES)`: width of the dmem word address.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `rvalid_i` in 1: byte valid from `uart_rx`.
- `rready_o` out 1: loader accepts a byte this cycle.
- `rdata_i` in 8: received byte.
- `imem_we_o` out 1: imem word write strobe.
- `imem_addr_o` out IMEM_AW: imem word address.
- `imem_wdata_o` out 32: imem write data.
- `dmem_we_o` out 1: dmem word write strobe.
- `dmem_addr_o` out DMEM_AW: dmem word address.
- `dmem_wdata_o` out 32: dmem write data.
- `cpu_rst_o` out 1: CPU reset, held high until loading is complete.
- `done_o` out 1: load complete.
- `err_o` out 1: checksum mismatch; only driven when `LOADER_CHECKSUM_EN` is defined, otherwise tied to 0.

## Operation
- A byte is transferred on any cycle where `rvalid_i & rready_o`.
- Byte-lane counter `lane[1:0]`: byte k of a word goes to bits `[8k+7:8k]` (little-endian; the first byte received is the LSB).
- On the transfer with `lane==3`: the word is complete, `lane` wraps to 0, and one write strobe is issued.
- States:
  - IMEM: words go to imem at address `widx`. After the write at `widx==IMEM_ENTRIES-1`, `widx` resets to 0 and the state moves to DMEM.
  - DMEM: the same scheme against dmem. After the last word, the state moves to CSUM if enabled, else DONE.
  - CSUM: receives one 4-byte word and compares it with the running sum, then moves to DONE.
  - DONE: terminal until reset.
- `rready_o` = 1 in IMEM, DMEM and CSUM; 0 in DONE. Extra bytes stay unconsumed.
- In DONE: `cpu_rst_o` = 0 and `done_o` = 1. In every other state: `cpu_rst_o` = 1 and `done_o` = 0.
- Reset values: state = IMEM, `lane` = 0, `widx` = 0, `rready_o` = 1, both write enables 0, both addresses 0, both wdata outputs 0, `cpu_rst_o` = 1, `done_o` = 0, `err_o` = 0.
- Reset mid-load discards the partial word. The next byte is treated as byte 0 of imem word 0.
- `rvalid_i` low mid-word: `lane` and the partial word are held indefinitely; there is no timeout.

## Timing
- Write latency: the write strobe, address and data are registered. They are valid for exactly 1 cycle, the cycle after the 4th byte's handshake.
- Strobes are never back-to-back. A new word needs at least 4 handshakes.
- Throughput: 1 byte per cycle when `rvalid_i` is held high.
- Transition IMEM→DMEM takes effect the cycle after the last imem byte. The final `imem_we_o` and the state change occur in the same cycle.
- `cpu_rst_o` falls, and `done_o` rises, in the cycle after the final dmem byte (or the final checksum byte). This is the same cycle as the last `dmem_we_o`, so the CPU leaves reset no earlier than the last memory write.
- Address width: `widx` is sized `max(IMEM_AW, DMEM_AW)+1` so it never wraps before its terminal compare.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - A 32-bit accumulator sums (mod 2^32) every imem and dmem word written.
  - The CSUM state receives one extra little-endian word.
  - On entry to DONE, `err_o` = (received ≠ sum); it stays registered until reset.
  - `cpu_rst_o` is released regardless of `err_o`.
- `LOADER_CHECKSUM_EN` not defined:
  - There is no CSUM state and no accumulator, and `err_o` is constant 0.
  - The byte stream is exactly 4·(IMEM_ENTRIES+DMEM_ENTRIES) bytes. This matches the simulation init sequence.

## Test plan
All scenarios use IMEM_ENTRIES=4 and DMEM_ENTRIES=2.
- **Word assembly:** after reset, stream bytes 0x78,0x56,0x34,0x12 → the next cycle shows `imem_we_o`=1, `imem_addr_o`=0, `imem_wdata_o`=0x12345678; no other strobe occurs.
- **Full load:** stream 24 bytes back-to-back → 4 imem writes at addresses 0..3, then 2 dmem writes at addresses 0..1. `cpu_rst_o` falls and `done_o` rises in the same cycle as the dmem write to address 1; `rready_o` is then 0, and a 25th byte held on `rvalid_i` is never accepted.
- **Stall:** deassert `rvalid_i` for 100 cycles after byte 2 of imem word 1 → no strobe is issued, and after resuming, `imem_wdata_o` holds the correct assembled word at address 1.
- **Reset mid-load:** assert `rst_i` after 10 bytes → all outputs return to their reset values; a fresh 24-byte stream loads correctly starting at imem address 0.
- **Checksum (`LOADER_CHECKSUM_EN`):** words 1,2,3,4,5,6 followed by checksum 0x15 → `err_o`=0 and `done_o`=1. The same words followed by checksum 0x16 → `err_o`=1 and `cpu_rst_o`=0.
